// File: rtl/ifetch_mem_ctrl.sv
// Instruction fetch controller between the PC stage and decode.
// It fetches one word per pc over req/gnt + rvalid and hands it to decode over valid/ready.
module ifetch_mem_ctrl #(
    parameter int WORD_BITWIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WORD_BITWIDTH-1:0] pc,
    input  logic                     flush,
    output logic                     stall_pc,
    output logic                     mem_req,
    output logic [WORD_BITWIDTH-1:0] mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [WORD_BITWIDTH-1:0] mem_rdata,
    output logic [WORD_BITWIDTH-1:0] instr,
    output logic [WORD_BITWIDTH-1:0] instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic                     fetch_err,
    output logic [1:0]               err_code,
    output logic [2:0]               dbg_state
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_DRAIN = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic                     mem_req_q, mem_req_d;
    logic [WORD_BITWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_BITWIDTH-1:0] instr_q, instr_d;
    logic [WORD_BITWIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                     instr_valid_q, instr_valid_d;
    logic                     fetch_err_q, fetch_err_d;
    logic [1:0]               err_code_q, err_code_d;
    logic [CW-1:0]            cnt_q, cnt_d;

    // Handshakes: a request transfers on a cycle with mem_req && mem_gnt; a
    // word transfers to decode on instr_valid && instr_ready. Once raised,
    // req/addr and valid/instr/instr_pc stay stable until the transfer
    // (or a flush).
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;
        err_code_d    = err_code_q;
        cnt_d         = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pc[1:0] != 2'b00) begin
                    state_d     = S_ERR;
                    fetch_err_d = 1'b1;
                    err_code_d  = 2'b01;
                end else begin
                    mem_addr_d = pc;
                    mem_req_d  = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (flush) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = mem_gnt ? S_DRAIN : S_IDLE;
                end else if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = mem_rvalid ? S_IDLE : S_DRAIN;
                end else if (mem_rvalid) begin
                    instr_d       = mem_rdata;
                    instr_pc_d    = mem_addr_q;
                    instr_valid_d = 1'b1;
                    state_d       = S_OUT;
                end else if (cnt_q == CNT_MAX) begin
                    fetch_err_d = 1'b1;
                    err_code_d  = 2'b10;
                    state_d     = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (flush || instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            S_DRAIN: begin
                // The outstanding response, or its timeout, ends the drain quietly.
                if (mem_rvalid || (cnt_q == CNT_MAX)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ERR: begin
                if (flush) begin
                    fetch_err_d = 1'b0;
                    err_code_d  = 2'b00;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            err_code_q    <= 2'b00;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            err_code_q    <= err_code_d;
            cnt_q         <= cnt_d;
        end
    end

    assign stall_pc    = (state_q != S_IDLE);
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;
    assign err_code    = err_code_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ifetch_mem_ctrl.sv
// Bench for ifetch_mem_ctrl: directed scenarios followed by randomized fetches
// checked against a transaction-level model of expected {pc, word} deliveries.
module tb_ifetch_mem_ctrl;

    localparam int W  = 32;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pc = '0;
    logic         flush = 1'b0;
    logic         stall_pc;
    logic         mem_req;
    logic [W-1:0] mem_addr;
    logic         mem_gnt = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [W-1:0] mem_rdata = '0;
    logic [W-1:0] instr;
    logic [W-1:0] instr_pc;
    logic         instr_valid;
    logic         instr_ready = 1'b0;
    logic         fetch_err;
    logic [1:0]   err_code;
    logic [2:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*W-1:0] exp_q[$];

    ifetch_mem_ctrl #(.WORD_BITWIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .pc(pc), .flush(flush), .stall_pc(stall_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .fetch_err(fetch_err), .err_code(err_code), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference rule: a pc that is not word aligned is reported as code 01.
    function automatic logic [1:0] model_err(input logic [W-1:0] p);
        return (p[1:0] != 2'b00) ? 2'b01 : 2'b00;
    endfunction

    // One complete fetch starting with the DUT idle; noise drives gnt/rvalid
    // in states where the protocol says they must be ignored.
    task automatic do_fetch(input logic [W-1:0] addr, input logic [W-1:0] data,
                            input int gnt_dly, input int rv_dly, input int rdy_dly,
                            input bit noise, input bit flush_out);
        logic [2*W-1:0] e;
        pc = addr;
        exp_q.push_back({addr, data});
        mem_rvalid = noise;
        mem_rdata  = $urandom;
        tick();
        chk("req_issued", {31'd0, mem_req}, 1);
        chk("req_addr", mem_addr, addr);
        chk("req_stall", {31'd0, stall_pc}, 1);
        pc = $urandom;
        repeat (gnt_dly) begin
            mem_gnt = 1'b0;
            tick();
            chk("req_hold", {31'd0, mem_req}, 1);
            chk("addr_hold", mem_addr, addr);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        chk("req_drop", {31'd0, mem_req}, 0);
        repeat (rv_dly) begin
            mem_gnt = noise;
            tick();
            chk("wait_novalid", {31'd0, instr_valid}, 0);
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        e = exp_q.pop_front();
        chk("out_valid", {31'd0, instr_valid}, 1);
        chk("out_instr", instr, e[W-1:0]);
        chk("out_pc", instr_pc, e[2*W-1:W]);
        repeat (rdy_dly) begin
            instr_ready = 1'b0;
            mem_rvalid  = noise;
            mem_gnt     = noise;
            tick();
            chk("hold_valid", {31'd0, instr_valid}, 1);
            chk("hold_instr", instr, e[W-1:0]);
            chk("hold_pc", instr_pc, e[2*W-1:W]);
            chk("hold_stall", {31'd0, stall_pc}, 1);
        end
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        if (flush_out) begin
            flush       = 1'b1;
            instr_ready = 1'($urandom_range(0, 1));
        end else begin
            instr_ready = 1'b1;
        end
        tick();
        flush       = 1'b0;
        instr_ready = 1'b0;
        chk("out_done", {31'd0, instr_valid}, 0);
        chk("idle_stall", {31'd0, stall_pc}, 0);
    endtask

    initial begin
        logic [W-1:0] a;
        // Reset state
        pc = 32'h100;
        tick();
        tick();
        chk("rst_req", {31'd0, mem_req}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_valid", {31'd0, instr_valid}, 0);
        chk("rst_err", {31'd0, fetch_err}, 0);
        chk("rst_code", {30'd0, err_code}, 0);
        chk("rst_stall", {31'd0, stall_pc}, 0);
        chk("rst_state", {29'd0, dbg_state}, 0);
        rst = 1'b0;

        // Zero-wait fetch, then delayed grant with decode back-pressure
        do_fetch(32'h100, 32'h0050_0093, 0, 0, 0, 1'b0, 1'b0);
        do_fetch(32'h200, $urandom, 3, 0, 4, 1'b0, 1'b0);

        // Flush while waiting: response is drained and dropped
        pc = 32'h300;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        pc    = 32'h400;
        chk("drain_valid", {31'd0, instr_valid}, 0);
        chk("drain_stall", {31'd0, stall_pc}, 1);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        tick();
        mem_rvalid = 1'b0;
        chk("drained_valid", {31'd0, instr_valid}, 0);
        chk("drained_idle", {31'd0, stall_pc}, 0);
        do_fetch(32'h400, 32'h1234_5678, 1, 1, 1, 1'b0, 1'b0);

        // Misaligned pc: sticky error, no request, cleared by flush
        pc = 32'h102;
        tick();
        chk("mis_err", {31'd0, fetch_err}, 1);
        chk("mis_code", {30'd0, err_code}, {30'd0, model_err(32'h102)});
        chk("mis_noreq", {31'd0, mem_req}, 0);
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        tick();
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        chk("mis_sticky", {31'd0, fetch_err}, 1);
        chk("mis_noreq2", {31'd0, mem_req}, 0);
        chk("mis_valid", {31'd0, instr_valid}, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("mis_clr_err", {31'd0, fetch_err}, 0);
        chk("mis_clr_code", {30'd0, err_code}, 0);

        // Timeout: grant with no response for TO wait cycles
        pc = 32'h500;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        repeat (TO - 1) tick();
        chk("to_early", {31'd0, fetch_err}, 0);
        tick();
        chk("to_err", {31'd0, fetch_err}, 1);
        chk("to_code", {30'd0, err_code}, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("to_clr", {30'd0, err_code}, 0);

        // Reset while presenting a word; late response must be ignored
        pc = 32'h600;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        chk("pre_rst_valid", {31'd0, instr_valid}, 1);
        rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, instr_valid}, 0);
        chk("async_instr", instr, 0);
        chk("async_stall", {31'd0, stall_pc}, 0);
        pc         = 32'h700;
        mem_rvalid = 1'b1;
        tick();
        chk("in_rst_req", {31'd0, mem_req}, 0);
        rst = 1'b0;
        do_fetch(32'h700, 32'h0000_0013, 0, 2, 0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                a  = ($urandom & 32'hFFFF_FFFC) | W'($urandom_range(1, 3));
                pc = a;
                tick();
                chk("rnd_mis_err", {31'd0, fetch_err}, 1);
                chk("rnd_mis_code", {30'd0, err_code}, {30'd0, model_err(a)});
                chk("rnd_mis_noreq", {31'd0, mem_req}, 0);
                flush = 1'b1;
                tick();
                flush = 1'b0;
                chk("rnd_mis_clr", {31'd0, fetch_err}, 0);
            end else begin
                do_fetch($urandom & 32'hFFFF_FFFC, $urandom,
                         $urandom_range(0, 3), $urandom_range(0, TO - 1),
                         $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 4) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
